lfsr_stream_arb: RTL and testbench
==================================

# lfsr_stream_arb

Controller that owns a single 26-bit maximal-length LFSR and shares it between two requesters. Each requester asks for a burst of pseudo-random words; the block arbitrates round-robin, seeds the LFSR on command, and streams one word per accepted beat over a valid/ready output. It sits between the random-number consumers and the LFSR datapath and is the only agent allowed to load or step it.

## Interface
- `LEN_W`, 4: width of burst-length inputs; value 0 encodes 2^LEN_W words
- `SEED_DEFAULT`, 26'h1: LFSR value after reset
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `seed_ld`  in  1  load `seed` into LFSR (honoured only in IDLE)
- `seed`  in  26  seed value; 0 is replaced by 26'h1
- `req`  in  2  per-requester burst request, level, held until `done`
- `len0`, `len1`  in  LEN_W  burst length for requester 0/1, sampled at grant
- `gnt`  out  2  one-hot grant, high for the whole burst
- `dout`  out  26  current random word
- `vld`  out  1  `dout` valid
- `rdy`  in  1  consumer accepts `dout` when `vld && rdy`
- `done`  out  1  one-cycle pulse after last word of a burst is accepted

## Operation
- LFSR step: next = {q[24:0], q[25]^q[5]^q[1]^q[0]} (taps 26,6,2,1). All-zero state is unreachable.
- States: IDLE, GEN.
- IDLE: `vld`=0, `gnt`=0.
  - `seed_ld`=1: LFSR <= (seed==0 ? 1 : seed); stay IDLE; any request waits (seed wins same-cycle tie).
  - else any `req`: pick winner; `gnt[w]`<=1; cnt <= len_w (0 -> 2^LEN_W); -> GEN.
- Arbitration: one requester asking -> it wins. Both asking -> the one not granted last. `last` resets to 1 so requester 0 wins the first tie.
- GEN, when `!vld || rdy`:
  - cnt != 0: LFSR <= next; `dout` <= next; `vld` <= 1; cnt <= cnt-1.
  - cnt == 0 (only after last word accepted): `vld`<=0, `gnt`<=0, `done`<=1, `last`<=w, -> IDLE.
- GEN with `vld && !rdy`: hold `dout`, `vld`, cnt and LFSR (no step while stalled).
- `seed_ld` during GEN is ignored and not remembered.
- `req` dropped mid-burst: ignored; burst completes. Burst length is fixed at grant.
- `len` changes after grant: no effect.

## Timing
- Reset values: `gnt`=0, `vld`=0, `done`=0, `dout`=0, LFSR=`SEED_DEFAULT`, state IDLE, `last`=1.
- Reset mid-burst returns all of the above on the next edge. No partial burst resumes.
- `req` seen in IDLE at edge k: `gnt` high after edge k. First word with `vld` high after edge k+1.
- With `rdy` held high: one word per cycle. N words over cycles k+2..k+N+1. `done` high for the cycle after the last accept, with `gnt` and `vld` low.
- Back-to-back bursts: IDLE occupies at least one cycle between bursts. Minimum gap of 1 cycle with `gnt`=0.
- `seed_ld` in IDLE: the next granted burst's first word is step(seed).
- `rdy` never feeds an output combinationally; all outputs are registered.

## Structure
- Shared package: LFSR width (26), tap constant/feedback function, state enum (IDLE, GEN), `SEED_DEFAULT`.
- One sub-module, `lfsr26_core`, with ports `clk`, `rst`, `load`, `din[25:0]`, `step`, `q[25:0]`. It handles the zero-seed substitution internally.
- The controller holds the FSM, round-robin pointer, burst counter and output registers.

## Test plan
- Seed 26'h1A in IDLE; req0, len0=3, `rdy`=1 -> `gnt`=01; `dout` = 26'h35, 26'h6A, 26'hD4 on consecutive cycles; `done` pulse; `gnt`=00.
- req0 and req1 asserted together after reset, len=2 each -> requester 0 served first, then requester 1 after one IDLE cycle; subsequent tie grants 0 again; exactly 2 words each.
- len1=0 -> 16 words, then `done`; counter wrap correct.
- `rdy` low for 3 cycles mid-burst -> `dout` and `vld` stable, LFSR not advanced, word sequence unchanged vs. no-stall run.
- `seed`=0 with `seed_ld` -> LFSR=1; first word 26'h3. Then `seed_ld` during GEN -> ignored, sequence continues unbroken.
- `rst` asserted on third word of 8-word burst -> next cycle all outputs 0, LFSR=1; new req0 starts fresh from step(1)=26'h3.

Source files
------------

// File: rtl/lfsr_stream_arb_pkg.sv
// Shared definitions for the two-requester LFSR stream arbiter:
// LFSR geometry, feedback function, controller states and default seed.
package lfsr_stream_arb_pkg;

  localparam int LFSR_W = 26;
  localparam logic [LFSR_W-1:0] SEED_DEFAULT = 26'h1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  // Fibonacci step with taps 26,6,2,1; shifts toward the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[24:0], q[25] ^ q[5] ^ q[1] ^ q[0]};
  endfunction

endpackage

// File: rtl/lfsr_stream_arb_lfsr26_core.sv
// 26-bit maximal-length LFSR register with load and step controls.
// A zero seed is replaced by 1 so the lock-up state can never be entered.
module lfsr26_core
  import lfsr_stream_arb_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = lfsr_stream_arb_pkg::SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] din,
  input  logic              step,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_r;
  logic [LFSR_W-1:0] seed_s;

  // Substitute 1 for an all-zero seed.
  always_comb begin
    seed_s = din;
    if (din == {LFSR_W{1'b0}}) begin
      seed_s = {{(LFSR_W-1){1'b0}}, 1'b1};
    end else begin
      seed_s = din;
    end
  end

  // LFSR state register; load has priority over step.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_r <= SEED_DEFAULT;
    end else if (load) begin
      q_r <= seed_s;
    end else if (step) begin
      q_r <= lfsr_next(q_r);
    end else begin
      q_r <= q_r;
    end
  end

  assign q = q_r;

endmodule

// File: rtl/lfsr_stream_arb.sv
// Round-robin controller sharing one 26-bit LFSR between two burst requesters,
// streaming one pseudo-random word per accepted beat over valid/ready.
module lfsr_stream_arb
  import lfsr_stream_arb_pkg::*;
#(
  parameter int                LEN_W        = 4,
  parameter logic [LFSR_W-1:0] SEED_DEFAULT = lfsr_stream_arb_pkg::SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seed_ld,
  input  logic [LFSR_W-1:0] seed,
  input  logic [1:0]        req,
  input  logic [LEN_W-1:0]  len0,
  input  logic [LEN_W-1:0]  len1,
  output logic [1:0]        gnt,
  output logic [LFSR_W-1:0] dout,
  output logic              vld,
  input  logic              rdy,
  output logic              done
);

  state_t            state_r, state_s;
  logic [1:0]        gnt_r, gnt_s;
  logic              vld_r, vld_s;
  logic [LFSR_W-1:0] dout_r, dout_s;
  logic              done_r, done_s;
  logic [LEN_W:0]    cnt_r, cnt_s;
  logic              last_r, last_s;
  logic              pick_s;
  logic [LEN_W-1:0]  sel_len_s;
  logic              lfsr_load_s;
  logic              lfsr_step_s;
  logic [LFSR_W-1:0] lfsr_q_s;

  lfsr26_core #(
    .SEED_DEFAULT(SEED_DEFAULT)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load_s),
    .din  (seed),
    .step (lfsr_step_s),
    .q    (lfsr_q_s)
  );

  // Next-state, arbitration and output-register next values.
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    vld_s       = vld_r;
    dout_s      = dout_r;
    done_s      = 1'b0;
    cnt_s       = cnt_r;
    last_s      = last_r;
    lfsr_load_s = 1'b0;
    lfsr_step_s = 1'b0;
    pick_s      = 1'b0;
    sel_len_s   = len0;
    case (state_r)
      IDLE: begin
        vld_s = 1'b0;
        gnt_s = 2'b00;
        if (seed_ld) begin
          lfsr_load_s = 1'b1;
        end else if (req != 2'b00) begin
          // On a tie the requester not served last wins.
          if (req == 2'b11) begin
            pick_s = ~last_r;
          end else begin
            pick_s = req[1];
          end
          sel_len_s = pick_s ? len1 : len0;
          gnt_s     = pick_s ? 2'b10 : 2'b01;
          if (sel_len_s == {LEN_W{1'b0}}) begin
            cnt_s = {1'b1, {LEN_W{1'b0}}};
          end else begin
            cnt_s = {1'b0, sel_len_s};
          end
          state_s = GEN;
        end else begin
          state_s = IDLE;
        end
      end
      GEN: begin
        if (!vld_r || rdy) begin
          if (cnt_r != {(LEN_W+1){1'b0}}) begin
            lfsr_step_s = 1'b1;
            dout_s      = lfsr_next(lfsr_q_s);
            vld_s       = 1'b1;
            cnt_s       = cnt_r - {{LEN_W{1'b0}}, 1'b1};
          end else begin
            vld_s   = 1'b0;
            gnt_s   = 2'b00;
            done_s  = 1'b1;
            last_s  = gnt_r[1];
            state_s = IDLE;
          end
        end else begin
          state_s = GEN;
        end
      end
      default: begin
        state_s = IDLE;
        vld_s   = 1'b0;
        gnt_s   = 2'b00;
      end
    endcase
  end

  // Controller and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      gnt_r   <= 2'b00;
      vld_r   <= 1'b0;
      dout_r  <= {LFSR_W{1'b0}};
      done_r  <= 1'b0;
      cnt_r   <= {(LEN_W+1){1'b0}};
      last_r  <= 1'b1;
    end else begin
      state_r <= state_s;
      gnt_r   <= gnt_s;
      vld_r   <= vld_s;
      dout_r  <= dout_s;
      done_r  <= done_s;
      cnt_r   <= cnt_s;
      last_r  <= last_s;
    end
  end

  assign gnt  = gnt_r;
  assign vld  = vld_r;
  assign dout = dout_r;
  assign done = done_r;

endmodule

// File: tb/tb_lfsr_stream_arb.sv
// Scoreboard bench for lfsr_stream_arb: stimulus pushes expected words from a
// reference model; a negedge monitor pops and compares on every accepted beat.
module tb_lfsr_stream_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        seed_ld;
  logic [25:0] seed;
  logic [1:0]  req;
  logic [3:0]  len0;
  logic [3:0]  len1;
  logic [1:0]  gnt;
  logic [25:0] dout;
  logic        vld;
  logic        rdy;
  logic        done;

  always #5 clk = ~clk;

  lfsr_stream_arb #(.LEN_W(4), .SEED_DEFAULT(26'h1)) dut (
    .clk(clk), .rst(rst), .seed_ld(seed_ld), .seed(seed), .req(req),
    .len0(len0), .len1(len1), .gnt(gnt), .dout(dout), .vld(vld),
    .rdy(rdy), .done(done)
  );

  typedef struct packed {
    logic [25:0] word;
    logic [1:0]  gnt;
  } exp_t;

  exp_t        exp_q[$];
  int          len_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          words_seen = 0;
  bit          mon_en = 1'b0;
  logic [25:0] m_lfsr;
  bit          m_last;
  logic [25:0] held;
  bit          held_v = 1'b0;
  exp_t        mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference LFSR: feedback is the parity of the tapped bits 26,6,2,1.
  function automatic logic [25:0] ref_step(input logic [25:0] v);
    logic fb;
    fb = ^(v & 26'h2000023);
    return {v[24:0], fb};
  endfunction

  function automatic bit ref_pick(input logic [1:0] r);
    if (r == 2'b11) return !m_last;
    return r[1];
  endfunction

  function automatic int ref_len(input logic [3:0] l);
    return (l == 4'd0) ? 16 : int'(l);
  endfunction

  task automatic push_burst(input bit w, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      m_lfsr = ref_step(m_lfsr);
      e.word = m_lfsr;
      e.gnt  = w ? 2'b10 : 2'b01;
      exp_q.push_back(e);
    end
    len_q.push_back(n);
  endtask

  // Monitor: compares every accepted beat and every done pulse.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (held_v && vld) check("stall_hold", 32'(dout), 32'(held));
      held_v = vld && !rdy;
      held   = dout;
      if (vld && rdy) begin
        words_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_word", 32'(0), 32'(1));
        end else begin
          mon_e = exp_q.pop_front();
          check("word", 32'(dout), 32'(mon_e.word));
          check("word_gnt", 32'(gnt), 32'(mon_e.gnt));
        end
      end
      if (done) begin
        check("done_gnt", 32'(gnt), 32'(0));
        check("done_vld", 32'(vld), 32'(0));
        if (len_q.size() == 0) check("unexpected_done", 32'(0), 32'(1));
        else check("burst_len", 32'(words_seen), 32'(len_q.pop_front()));
        words_seen = 0;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  // mode 0: rdy high; 1: random rdy/len/seed_ld; 2: rdy low 3 cycles; 3: seed_ld held
  task automatic wait_done(input int mode);
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (done) return;
      case (mode)
        1: begin
          rdy     = ($urandom_range(0, 3) != 0);
          seed_ld = ($urandom_range(0, 7) == 0);
          seed    = 26'($urandom);
          len0    = 4'($urandom_range(0, 15));
          len1    = 4'($urandom_range(0, 15));
        end
        2: rdy = !(c >= 3 && c <= 5);
        3: begin rdy = 1'b1; seed_ld = 1'b1; seed = 26'h155; end
        default: rdy = 1'b1;
      endcase
    end
    check("done_timeout", 32'(0), 32'(1));
    finish_run();
  endtask

  task automatic serve(input logic [1:0] mask, input logic [3:0] l0, input logic [3:0] l1, input int mode);
    bit w;
    logic [1:0] pend;
    pend = mask;
    len0 = l0;
    len1 = l1;
    rdy  = 1'b1;
    while (pend != 2'b00) begin
      w = ref_pick(pend);
      push_burst(w, ref_len(w ? len1 : len0));
      req = pend;
      wait_done(mode);
      seed_ld = 1'b0;
      pend[w] = 1'b0;
      m_last  = w;
      req     = pend;
    end
    rdy = 1'b1;
  endtask

  task automatic load_seed(input logic [25:0] s);
    seed = s; seed_ld = 1'b1;
    @(posedge clk); #1;
    seed_ld = 1'b0;
    m_lfsr = (s == 26'd0) ? 26'h1 : s;
  endtask

  // Requester-0 burst with explicit latency and first-word checks.
  task automatic burst0_first(input int n, input logic [25:0] first);
    push_burst(1'b0, n);
    len0 = 4'(n); req = 2'b01; rdy = 1'b1;
    @(posedge clk); #1;
    check("grant_latency_gnt", 32'(gnt), 32'(2'b01));
    check("grant_latency_vld", 32'(vld), 32'(0));
    @(posedge clk); #1;
    check("first_word_vld", 32'(vld), 32'(1));
    check("first_word", 32'(dout), 32'(first));
    wait_done(0);
    m_last = 1'b0;
    req = 2'b00;
    @(posedge clk); #1;
    check("done_one_cycle", 32'(done), 32'(0));
  endtask

  initial begin
    rst = 1'b1; seed_ld = 1'b0; seed = 26'd0; req = 2'b00;
    len0 = 4'd0; len1 = 4'd0; rdy = 1'b1;
    m_lfsr = 26'h1; m_last = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_vld", 32'(vld), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_dout", 32'(dout), 32'(0));
    rst = 1'b0;
    mon_en = 1'b1;

    serve(2'b11, 4'd2, 4'd2, 0);
    serve(2'b11, 4'd2, 4'd2, 0);

    load_seed(26'h1A);
    burst0_first(3, 26'h35);

    serve(2'b10, 4'd5, 4'd0, 0);
    serve(2'b01, 4'd8, 4'd3, 2);

    load_seed(26'd0);
    burst0_first(2, 26'h3);
    serve(2'b01, 4'd6, 4'd1, 3);

    // seed_ld and req in the same IDLE cycle: the seed wins, the request waits
    seed = 26'h2ABC; seed_ld = 1'b1; req = 2'b01; len0 = 4'd2;
    m_lfsr = 26'h2ABC;
    push_burst(1'b0, 2);
    @(posedge clk); #1;
    seed_ld = 1'b0;
    check("seed_tie_gnt", 32'(gnt), 32'(0));
    wait_done(0);
    m_last = 1'b0;
    req = 2'b00;

    // reset while the third word of an eight-word burst is presented
    mon_en = 1'b0;
    req = 2'b01; len0 = 4'd8; rdy = 1'b1;
    repeat (4) @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_gnt", 32'(gnt), 32'(0));
    check("midrst_vld", 32'(vld), 32'(0));
    check("midrst_done", 32'(done), 32'(0));
    check("midrst_dout", 32'(dout), 32'(0));
    rst = 1'b0; req = 2'b00;
    exp_q.delete(); len_q.delete(); words_seen = 0;
    m_lfsr = 26'h1; m_last = 1'b1;
    mon_en = 1'b1;
    burst0_first(3, 26'h3);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 3) == 0) load_seed(26'($urandom));
      serve(2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
    end

    repeat (3) @(posedge clk); #1;
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));
    check("final_len_empty", 32'(len_q.size()), 32'(0));
    finish_run();
  end

endmodule
